// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: sequencing controller for the UART transmit path.
// Drives load/shift strobes of an external 8-bit PISO shifter and frames
// its serial bit with a start bit and one or two stop bits.
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       piso_bit,
  output logic [7:0] piso_data,
  output logic       load_out,
  output logic       shift_out,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Stop counter only needs to distinguish the first and second stop bit.
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_r,     state_s;
  logic [CNT_W-1:0] cnt_r,       cnt_s;
  logic [2:0]       bit_idx_r,   bit_idx_s;
  logic             stop_cnt_r,  stop_cnt_s;
  logic [7:0]       piso_data_r, piso_data_s;
  logic             done_r,      done_s;

  // State, counters, capture register and completion flag.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      bit_idx_r   <= 3'd0;
      stop_cnt_r  <= 1'b0;
      piso_data_r <= 8'h00;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      bit_idx_r   <= bit_idx_s;
      stop_cnt_r  <= stop_cnt_s;
      piso_data_r <= piso_data_s;
      done_r      <= done_s;
    end
  end

  // Next-state logic: bit-period timing and frame sequencing.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    bit_idx_s   = bit_idx_r;
    stop_cnt_s  = stop_cnt_r;
    piso_data_s = piso_data_r;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (tx_start) begin
          piso_data_s = tx_data;
          cnt_s       = '0;
          stop_cnt_s  = 1'b0;
          state_s     = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s     = '0;
          bit_idx_s = 3'd0;
          state_s   = DATA;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s = '0;
          if (bit_idx_r != 3'd7) begin
            bit_idx_s = bit_idx_r + 3'd1;
          end else begin
            stop_cnt_s = 1'b0;
            state_s    = STOP;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s = '0;
          if (stop_cnt_r == STOP_LAST) begin
            done_s  = 1'b1;
            state_s = IDLE;
          end else begin
            stop_cnt_s = stop_cnt_r + 1'b1;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // Output decode from registered state; only the DATA line follows piso_bit.
  always_comb begin
    tx_out    = 1'b1;
    load_out  = 1'b0;
    shift_out = 1'b0;
    tx_busy   = 1'b1;
    case (state_r)
      IDLE: begin
        tx_busy = 1'b0;
      end
      START: begin
        tx_out   = 1'b0;
        // Two loads: the first primes the shifter, the second publishes bit 0.
        load_out = (cnt_r == '0) || (cnt_r == CNT_ONE);
      end
      DATA: begin
        tx_out    = piso_bit;
        shift_out = (cnt_r == CNT_LAST) && (bit_idx_r != 3'd7);
      end
      STOP: begin
        tx_out = 1'b1;
      end
      default: begin
        tx_busy = 1'b0;
      end
    endcase
  end

  assign piso_data = piso_data_r;
  assign tx_done   = done_r;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: two instances (4 clk/bit 1 stop,
// 5 clk/bit 2 stop), each with a behavioural PISO shifter and a line monitor.
module tb_uart_tx_ctrl;

  typedef struct packed {
    logic [7:0] data;
    logic       aborted;
    logic       chk_gap;
  } exp_t;

  logic       Clk;
  logic       reset;
  logic       tx_start_s [2];
  logic [7:0] tx_data_s  [2];
  int         cyc;
  int         n_cmp;
  int         n_fail;
  exp_t       exp_q [2][$];

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Free-running cycle counter used for frame gap measurement.
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp = n_cmp + 1;
    if (act !== req) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int C = (g == 0) ? 4 : 5;
    localparam int S = (g == 0) ? 1 : 2;
    localparam int L = (9 + S) * C + 1;

    logic [7:0] piso_data_s;
    logic       load_s, shift_s, tx_out_s, tx_busy_s, tx_done_s, piso_bit_s;
    logic [7:0] sreg;

    uart_tx_ctrl #(.CLKS_PER_BIT(C), .STOP_BITS(S)) u_dut (
      .Clk       (Clk),
      .reset     (reset),
      .tx_start  (tx_start_s[g]),
      .tx_data   (tx_data_s[g]),
      .piso_bit  (piso_bit_s),
      .piso_data (piso_data_s),
      .load_out  (load_s),
      .shift_out (shift_s),
      .tx_out    (tx_out_s),
      .tx_busy   (tx_busy_s),
      .tx_done   (tx_done_s)
    );

    // Shifter model: load publishes old bit 0, shift publishes next bit.
    always @(posedge Clk) begin
      if (reset) begin
        sreg       <= 8'h00;
        piso_bit_s <= 1'b0;
      end else if (load_s) begin
        piso_bit_s <= sreg[0];
        sreg       <= piso_data_s;
      end else if (shift_s) begin
        piso_bit_s <= sreg[1];
        sreg       <= {1'b0, sreg[7:1]};
      end
    end

    // Monitor: capture each frame from busy rise, pop expectation, compare.
    initial begin : mon
      bit ln [L];
      bit ld [L];
      bit sh [L];
      bit bs [L];
      bit dn [L];
      bit busy_prev, abort, eb;
      int n, start_cyc, last_end, p, line_err, ld_err, sh_err, bs_err, dn_err;
      logic [7:0] got;
      exp_t e;
      busy_prev = 1'b0;
      last_end  = -100;
      forever begin
        @(negedge Clk);
        if (tx_busy_s === 1'b1 && !busy_prev) begin
          start_cyc = cyc;
          n = 0;
          abort = 1'b0;
          while (n < L && !abort) begin
            if (n > 0) @(negedge Clk);
            ln[n] = (tx_out_s === 1'b1);
            ld[n] = (load_s === 1'b1);
            sh[n] = (shift_s === 1'b1);
            bs[n] = (tx_busy_s === 1'b1);
            dn[n] = (tx_done_s === 1'b1);
            if (n < L - 1 && !bs[n]) abort = 1'b1;
            n = n + 1;
          end
          if (exp_q[g].size() == 0) begin
            check("unexpected_frame", 32'd1, 32'd0);
          end else begin
            e = exp_q[g].pop_front();
            check("frame_aborted", {31'd0, abort}, {31'd0, e.aborted});
            if (abort) begin
              check("abort_idle_outputs", {28'd0, ln[n-1], ld[n-1], sh[n-1], dn[n-1]}, 32'h8);
            end else begin
              line_err = 0; ld_err = 0; sh_err = 0; bs_err = 0; dn_err = 0;
              for (int i = 0; i < L; i++) begin
                p = i / C;
                if (p == 0) eb = 1'b0;
                else if (p <= 8) eb = e.data[p-1];
                else eb = 1'b1;
                if (ln[i] != eb) line_err++;
                if (ld[i] != (i == 0 || i == 1)) ld_err++;
                if (sh[i] != ((i % C == C - 1) && p >= 1 && p <= 7)) sh_err++;
                if (bs[i] != (i < L - 1)) bs_err++;
                if (dn[i] != (i == L - 1)) dn_err++;
              end
              for (int b = 0; b < 8; b++) got[b] = ln[(b + 1) * C + C / 2];
              check("byte", {24'd0, got}, {24'd0, e.data});
              check("line_cycles_wrong", line_err, 32'd0);
              check("load_cycles_wrong", ld_err, 32'd0);
              check("shift_cycles_wrong", sh_err, 32'd0);
              check("busy_cycles_wrong", bs_err, 32'd0);
              check("done_cycles_wrong", dn_err, 32'd0);
              if (e.chk_gap) check("idle_gap", start_cyc - last_end - 1, 32'd1);
              last_end = start_cyc + L - 2;
            end
          end
          busy_prev = bs[n-1];
        end else begin
          busy_prev = (tx_busy_s === 1'b1);
        end
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input int g, input logic [7:0] d, input bit ab);
    exp_t e;
    e.data    = d;
    e.aborted = ab;
    e.chk_gap = 1'b0;
    exp_q[g].push_back(e);
    tx_data_s[g]  = d;
    tx_start_s[g] = 1'b1;
    step();
    tx_start_s[g] = 1'b0;
  endtask

  initial begin
    exp_t e;
    bit found;
    n_cmp = 0;
    n_fail = 0;
    cyc = 0;
    reset = 1'b1;
    tx_start_s[0] = 1'b0; tx_start_s[1] = 1'b0;
    tx_data_s[0]  = 8'h00; tx_data_s[1] = 8'h00;
    repeat (3) step();
    check("reset_outs0", {27'd0, g_inst[0].tx_out_s, g_inst[0].load_s, g_inst[0].shift_s,
          g_inst[0].tx_busy_s, g_inst[0].tx_done_s}, 32'h10);
    check("reset_piso0", {24'd0, g_inst[0].piso_data_s}, 32'h0);
    check("reset_outs1", {27'd0, g_inst[1].tx_out_s, g_inst[1].load_s, g_inst[1].shift_s,
          g_inst[1].tx_busy_s, g_inst[1].tx_done_s}, 32'h10);
    reset = 1'b0;
    repeat (2) step();

    // Basic frame and strobe-count frames.
    send(0, 8'hA5, 1'b0);
    repeat (45) step();
    send(0, 8'h00, 1'b0);
    repeat (45) step();
    send(0, 8'hFF, 1'b0);
    check("piso_data_ff", {24'd0, g_inst[0].piso_data_s}, 32'hFF);
    repeat (45) step();

    // Busy rejection: second request mid-DATA is ignored.
    send(0, 8'h81, 1'b0);
    repeat (12) step();
    tx_data_s[0] = 8'h3C;
    tx_start_s[0] = 1'b1;
    step();
    tx_start_s[0] = 1'b0;
    check("piso_hold_81", {24'd0, g_inst[0].piso_data_s}, 32'h81);
    repeat (40) step();
    check("busy_after_reject", {31'd0, g_inst[0].tx_busy_s}, 32'd0);
    repeat (10) step();

    // Back-to-back frames with tx_start held through tx_done.
    e.data = 8'h55; e.aborted = 1'b0; e.chk_gap = 1'b0;
    exp_q[0].push_back(e);
    e.data = 8'hAA; e.chk_gap = 1'b1;
    exp_q[0].push_back(e);
    tx_data_s[0] = 8'h55;
    tx_start_s[0] = 1'b1;
    step();
    tx_data_s[0] = 8'hAA;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      step();
      if (g_inst[0].tx_done_s === 1'b1) found = 1'b1;
    end
    check("b2b_done_seen", {31'd0, found}, 32'd1);
    step();
    tx_start_s[0] = 1'b0;
    repeat (45) step();

    // Reset during bit 3 abandons the frame.
    send(0, 8'hF0, 1'b1);
    repeat (16) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset_outs", {27'd0, g_inst[0].tx_out_s, g_inst[0].load_s, g_inst[0].shift_s,
          g_inst[0].tx_busy_s, g_inst[0].tx_done_s}, 32'h10);
    step();
    check("midreset_no_done", {31'd0, g_inst[0].tx_done_s}, 32'd0);
    send(0, 8'h0F, 1'b0);
    repeat (45) step();

    // Two stop bits at 5 clocks per bit.
    send(1, 8'h01, 1'b0);
    repeat (62) step();

    repeat (5) step();
    check("queue0_drained", exp_q[0].size(), 32'd0);
    check("queue1_drained", exp_q[1].size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Sequencing controller for the UART transmit path. It accepts a byte with a single-cycle start request, drives the load and shift strobes of the transmitter's 8-bit parallel-in/serial-out shifter, and frames the shifter's serial bit with a start bit and stop bit(s). The result is a complete 8N1/8N2 line signal. It sits between the host-side byte interface and the TX pin.

## Interface
- CLKS_PER_BIT, default 868: Clk cycles per bit period (100 MHz / 115200). Legal range is 4 and up.
- STOP_BITS, default 1: number of stop bits. Legal values are 1 or 2.

- Clk, input, 1: single system clock. All logic is on the rising edge.
- reset, input, 1: synchronous, active-high. It is shared with the shifter.
- tx_start, input, 1: start request. It is sampled only in IDLE.
- tx_data, input, 8: byte to send. It is captured on the accepted tx_start edge.
- piso_bit, input, 1: serial output of the shifter.
- piso_data, output, 8: parallel load value to the shifter. It is held from the capture register.
- load_out, output, 1: shifter load strobe.
- shift_out, output, 1: shifter shift strobe, one bit right.
- tx_out, output, 1: serial line. The idle level is 1.
- tx_busy, output, 1: high from acceptance until the last stop-bit cycle, inclusive.
- tx_done, output, 1: one-cycle completion pulse.

## Operation
- States: IDLE, START, DATA, STOP. There is one registered state, a baud counter `cnt` (width clog2(CLKS_PER_BIT)), a bit index `bit_idx` (3 bits) and a stop counter.
- Shifter contract:
  - On a load strobe, the shifter publishes the bit 0 of its previous contents. Two consecutive load strobes are therefore required before tx_data[0] appears on piso_bit.
  - Each shift strobe presents the next bit on piso_bit one cycle later.
- IDLE:
  - Outputs: tx_out=1, tx_busy=0.
  - When tx_start=1, capture tx_data into piso_data, clear cnt, and move to START.
- START:
  - Outputs: tx_out=0.
  - load_out=1 when cnt=0 and when cnt=1; it is 0 otherwise.
  - At cnt=CLKS_PER_BIT-1, clear cnt, set bit_idx=0, and move to DATA.
- DATA:
  - Outputs: tx_out=piso_bit.
  - At cnt=CLKS_PER_BIT-1:
    - If bit_idx<7: shift_out=1 for that single cycle, increment bit_idx, clear cnt.
    - If bit_idx=7: no shift; move to STOP.
- STOP:
  - Outputs: tx_out=1.
  - Runs for STOP_BITS×CLKS_PER_BIT cycles, then moves to IDLE with tx_done=1 for that single cycle.
- Strobe exclusivity: load_out and shift_out are never high in the same cycle. Both are 0 outside START and DATA.
- tx_start handling:
  - Ignored in START, DATA and STOP. There is no queuing.
  - Changes on tx_data after capture have no effect.
- Back-to-back frames: tx_start high in the IDLE cycle that carries tx_done is accepted. This gives exactly one idle-level cycle between frames.
- Reset mid-frame: on the next edge the block goes to IDLE, with tx_out=1, load_out=0, shift_out=0, tx_busy=0, tx_done=0. The partial frame is abandoned. No tx_done is issued for it.

## Timing
- Reset values:
  - state=IDLE, cnt=0, bit_idx=0, piso_data=0.
  - tx_out=1, load_out=0, shift_out=0, tx_busy=0, tx_done=0.
- All outputs are decoded from registered state and registered inputs. There is no combinational path from tx_start or tx_data to any output.
- tx_start sampled at edge E:
  - The start bit (tx_out=0) and tx_busy=1 appear in the cycle after E.
  - load_out is high in the first two START cycles.
- Bit n (n=0..7) occupies cycles E+1+(n+1)·CLKS_PER_BIT through E+(n+2)·CLKS_PER_BIT.
- Stop level spans STOP_BITS·CLKS_PER_BIT cycles.
- Frame length (start bit to last stop cycle) is (9+STOP_BITS)·CLKS_PER_BIT cycles.
- tx_done is asserted at cycle E+1+(9+STOP_BITS)·CLKS_PER_BIT.
- Exactly 7 shift_out pulses and exactly 2 load_out pulses occur per frame.

## Test plan
1. Basic frame: CLKS_PER_BIT=4, STOP_BITS=1, tx_data=0xA5.
   - tx_out reads 0, then LSB-first 1,0,1,0,0,1,0,1, then 1. Each bit is held 4 cycles.
   - tx_done is exactly 41 cycles after the accepting edge. tx_busy is high for 40 cycles.
2. Strobe count: tx_data=0x00 then 0xFF.
   - Each frame has exactly 2 load_out pulses (START cycles 0–1) and 7 shift_out pulses, each at the last cycle of bits 0–6.
   - The line data matches all-0s, then all-1s.
3. Busy rejection: tx_start pulsed with 0x3C mid-DATA of a 0x81 frame.
   - The line carries 0x81 only.
   - No second frame follows, and tx_busy falls after the single stop bit.
4. Back-to-back: tx_start held high through tx_done, with 0x55 then 0xAA.
   - The second start bit begins one idle cycle after the first frame's last stop cycle.
   - Both bytes are correct.
5. Reset mid-frame: reset is asserted for 1 cycle at bit 3 of 0xF0.
   - Next cycle: tx_out=1, tx_busy=0, strobes=0, and no tx_done.
   - A subsequent 0x0F frame is transmitted correctly.
6. STOP_BITS=2, CLKS_PER_BIT=5, tx_data=0x01.
   - The stop level lasts 10 cycles.
   - tx_done is 56 cycles after the accepting edge.
